toggle_activity_monitor: RTL and testbench
==========================================

TOGGLE_ACTIVITY_MONITOR -- requirements
Module: toggle_activity_monitor

Interface
REQ-001 Parameter WIDTH, default 8: probe bus width in bits (1..32).
REQ-002 Parameter WINDOW, default 256: measurement window length in clock cycles (2..65535).
REQ-003 Parameter CNT_W, default 16: width of every toggle counter.
REQ-004 Port clk, input, 1: single clock; all logic rising-edge triggered.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port start, input, 1: pulse that begins a measurement; honoured only in IDLE.
REQ-007 Port probe, input, WIDTH: signals under observation (e.g. DUT q/qb, stimulus bits).
REQ-008 Port bit_sel, input, max(1,$clog2(WIDTH)): selects the per-bit count shown on bit_count.
REQ-009 Port busy, output, 1: high in ARM and COUNT.
REQ-010 Port res_valid, output, 1: result available; high only in DONE.
REQ-011 Port res_ready, input, 1: consumer accepts the result.
REQ-012 Port toggle_total, output, CNT_W: total bit transitions in the window, all bits.
REQ-013 Port bit_count, output, CNT_W: transitions of probe[bit_sel] in the window.
REQ-014 Port overflow, output, 1: some counter saturated during the window.

Function
REQ-015 FSM states IDLE, ARM, COUNT, DONE; transitions occur only on clk rising edge.
REQ-016 IDLE->ARM when start=1; in ARM, counters and overflow clear and probe is captured into prev.
REQ-017 ARM->COUNT unconditionally after one cycle; COUNT lasts exactly WINDOW cycles.
REQ-018 Each COUNT cycle: toggle_total += popcount(probe ^ prev); per-bit counter i += probe[i]^prev[i]; then prev <= probe.
REQ-019 Every counter saturates at 2^CNT_W-1 and never wraps; any saturating add sets overflow, which stays set until the next ARM.
REQ-020 COUNT->DONE after the WINDOW-th COUNT cycle; res_valid is high in the cycle after the last counted sample, i.e. WINDOW+2 cycles after start is sampled.
REQ-021 DONE->IDLE on the cycle where res_valid=1 and res_ready=1; result outputs are stable while res_valid=1 and res_ready=0.
REQ-022 Result outputs hold their values in IDLE until the next ARM clears them.
REQ-023 start is ignored in ARM, COUNT and DONE; start and res_ready asserted together in DONE completes the handshake only and does not start a new window.
REQ-024 bit_sel is combinational to bit_count; bit_sel >= WIDTH yields bit_count=0.

Reset
REQ-025 rst=1 at any clk edge, in any state, forces IDLE; clears busy, res_valid, overflow, toggle_total, every per-bit counter and prev; a measurement interrupted by reset is discarded.
REQ-026 rst takes priority over start and res_ready in the same cycle.

Configuration
REQ-027 Macro TOGGLE_ACTIVITY_PERBIT_EN defined: WIDTH per-bit counters are built and bit_count behaves as in REQ-013/018/024.
REQ-028 Macro TOGGLE_ACTIVITY_PERBIT_EN undefined: no per-bit counters exist; bit_count is tied to 0; bit_sel is unused; overflow reflects toggle_total only; all other behaviour unchanged.

Verification (WIDTH=8, WINDOW=16, CNT_W=16, macro defined unless stated)
REQ-029 probe held at 0x5A throughout, start pulse -> res_valid 18 cycles after start, toggle_total=0, overflow=0.
REQ-030 probe alternates 0x00/0xFF every cycle -> toggle_total=128; bit_count=16 for any bit_sel 0..7.
REQ-031 Only probe[0] toggles every cycle, bit_sel=0 then 1 -> toggle_total=16, bit_count=16 then 0.
REQ-032 CNT_W=4, probe alternating 0x00/0xFF -> toggle_total=15, bit_count(0)=15, overflow=1.
REQ-033 rst pulsed for 1 cycle during the 5th COUNT cycle, then a new start with 0x00/0xFF alternation -> busy=0 and counters 0 right after reset; the second window reports toggle_total=128.
REQ-034 res_ready held low for 5 cycles in DONE -> res_valid and values stable; a start pulse in that interval is ignored; res_ready=1 -> IDLE the next cycle, busy=0; with the macro undefined, the same stimulus gives bit_count=0.

Source files
------------

// File: rtl/toggle_activity_monitor.sv
// Toggle activity monitor: counts probe bit transitions over a fixed window of cycles.
// Optional per-bit counters are built when TOGGLE_ACTIVITY_PERBIT_EN is defined.
module toggle_activity_monitor #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned WINDOW = 256,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] probe,
  input  logic [SEL_W-1:0] bit_sel,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] toggle_total,
  output logic [CNT_W-1:0] bit_count,
  output logic             overflow
);

  localparam int unsigned WIN_W = $clog2(WINDOW);
  localparam int unsigned POP_W = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   prev;
  logic [WIN_W-1:0]   win_cnt;
  logic [WIDTH-1:0]   diff;
  logic [POP_W-1:0]   pop;
  logic [SUM_W-1:0]   total_sum;
  logic               total_sat;
  logic               bit_sat;

  // Transitions seen this cycle and the saturating running total
  always_comb begin
    diff = probe ^ prev;
    pop  = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + POP_W'(diff[i]);
    total_sum = SUM_W'(toggle_total) + SUM_W'(pop);
    total_sat = |total_sum[SUM_W-1:CNT_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      res_valid    <= 1'b0;
      overflow     <= 1'b0;
      toggle_total <= '0;
      prev         <= '0;
      win_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          toggle_total <= '0;
          overflow     <= 1'b0;
          prev         <= probe;
          win_cnt      <= '0;
          state        <= COUNT;
        end
        COUNT: begin
          toggle_total <= total_sat ? {CNT_W{1'b1}} : total_sum[CNT_W-1:0];
          if (total_sat || bit_sat) overflow <= 1'b1;
          prev <= probe;
          if (win_cnt == WIN_W'(WINDOW - 1)) begin
            state     <= DONE;
            busy      <= 1'b0;
            res_valid <= 1'b1;
          end else begin
            win_cnt <= win_cnt + WIN_W'(1);
          end
        end
        DONE: begin
          // start is deliberately ignored here, even alongside res_ready
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TOGGLE_ACTIVITY_PERBIT_EN
  logic [CNT_W-1:0] bit_cnt [WIDTH];

  // A per-bit add saturates when that bit toggles with its counter already full
  always_comb begin
    bit_sat = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (diff[i] && (&bit_cnt[i])) bit_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state == ARM) begin
      for (int i = 0; i < WIDTH; i++) bit_cnt[i] <= '0;
    end else if (state == COUNT) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (diff[i] && !(&bit_cnt[i])) bit_cnt[i] <= bit_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign bit_count = (32'(bit_sel) < WIDTH) ? bit_cnt[bit_sel] : '0;
`else
  logic unused_bit_sel;

  assign bit_sat        = 1'b0;
  assign bit_count      = '0;
  assign unused_bit_sel = ^bit_sel;
`endif

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Bench for toggle_activity_monitor: directed and random windows against a sample-list model,
// run on a CNT_W=16 instance and a CNT_W=4 instance sharing the same stimulus.
module tb_toggle_activity_monitor;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned WINDOW  = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned SMALL_W = 4;

`ifdef TOGGLE_ACTIVITY_PERBIT_EN
  localparam bit PERBIT = 1'b1;
`else
  localparam bit PERBIT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               res_ready;
  logic [WIDTH-1:0]   probe;
  logic [2:0]         bit_sel;
  logic               busy, res_valid, overflow;
  logic [CNT_W-1:0]   toggle_total, bit_count;
  logic               busy_s, res_valid_s, overflow_s;
  logic [SMALL_W-1:0] toggle_total_s, bit_count_s;

  int checks = 0;
  int errors = 0;

  // Model results for the current window
  int exp_total;
  int exp_bits [WIDTH];

  always #5 clk = ~clk;

  toggle_activity_monitor #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .probe(probe), .bit_sel(bit_sel),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .toggle_total(toggle_total), .bit_count(bit_count), .overflow(overflow)
  );

  toggle_activity_monitor #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(SMALL_W)) dut_small (
    .clk(clk), .rst(rst), .start(start), .probe(probe), .bit_sel(bit_sel),
    .busy(busy_s), .res_valid(res_valid_s), .res_ready(res_ready),
    .toggle_total(toggle_total_s), .bit_count(bit_count_s), .overflow(overflow_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic bit ovf(input int w);
    bit o;
    o = (exp_total > (1 << w) - 1);
    if (PERBIT) begin
      for (int b = 0; b < WIDTH; b++) if (exp_bits[b] > (1 << w) - 1) o = 1'b1;
    end
    return o;
  endfunction

  // Compare both instances' result outputs against the model, sweeping bit_sel
  task automatic check_results(input string tag);
    check({tag, " res_valid"},   32'(res_valid), 32'd1);
    check({tag, " res_valid_s"}, 32'(res_valid_s), 32'd1);
    check({tag, " busy"},        32'(busy), 32'd0);
    check({tag, " total"},       32'(toggle_total), 32'(sat(exp_total, CNT_W)));
    check({tag, " total_s"},     32'(toggle_total_s), 32'(sat(exp_total, SMALL_W)));
    check({tag, " ovf"},         32'(overflow), 32'(ovf(CNT_W)));
    check({tag, " ovf_s"},       32'(overflow_s), 32'(ovf(SMALL_W)));
    for (int b = 0; b < WIDTH; b++) begin
      bit_sel = 3'(b);
      #1;
      check($sformatf("%s bit%0d", tag, b), 32'(bit_count),
            PERBIT ? 32'(sat(exp_bits[b], CNT_W)) : 32'd0);
      check($sformatf("%s bit%0d_s", tag, b), 32'(bit_count_s),
            PERBIT ? 32'(sat(exp_bits[b], SMALL_W)) : 32'd0);
    end
    bit_sel = 3'd0;
  endtask

  // mode 0: constant 0x5A, 1: 00/FF alternation, 2: only bit 0 toggles, else random
  task automatic run_window(input string tag, input int mode, input int hold, input bit start_with_ready);
    logic [WIDTH-1:0] pat [WINDOW+1];
    logic [WIDTH-1:0] d;
    for (int k = 0; k <= WINDOW; k++) begin
      case (mode)
        0:       pat[k] = 8'h5A;
        1:       pat[k] = (k % 2 == 1) ? 8'hFF : 8'h00;
        2:       pat[k] = 8'(k % 2);
        default: pat[k] = 8'($urandom);
      endcase
    end
    exp_total = 0;
    for (int b = 0; b < WIDTH; b++) exp_bits[b] = 0;
    for (int k = 1; k <= WINDOW; k++) begin
      d = pat[k] ^ pat[k-1];
      exp_total += $countones(d);
      for (int b = 0; b < WIDTH; b++) exp_bits[b] += int'(d[b]);
    end

    @(negedge clk);
    start = 1'b1;
    probe = pat[0];
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_arm"}, 32'(busy), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= WINDOW; k++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b1)
        check($sformatf("%s early_k%0d", tag, k), {30'd0, busy, res_valid}, 32'd2);
      probe = pat[k];
      @(posedge clk);
    end
    @(negedge clk);
    probe = 8'($urandom);
    check_results({tag, " done"});

    // Consumer stalls; a start pulse during the stall must be ignored
    for (int i = 0; i < hold; i++) begin
      start = (i == 1);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      probe = 8'($urandom);
      check($sformatf("%s hold%0d valid", tag, i), 32'(res_valid), 32'd1);
      check($sformatf("%s hold%0d total", tag, i), 32'(toggle_total), 32'(sat(exp_total, CNT_W)));
    end
    res_ready = 1'b1;
    start     = start_with_ready;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    check({tag, " idle valid"}, 32'(res_valid), 32'd0);
    check({tag, " idle busy"},  32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, " idle2 busy"},  32'(busy), 32'd0);
    check({tag, " idle2 total"}, 32'(toggle_total), 32'(sat(exp_total, CNT_W)));
    check({tag, " idle2 ovf_s"}, 32'(overflow_s), 32'(ovf(SMALL_W)));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " busy"},    32'(busy), 32'd0);
    check({tag, " valid"},   32'(res_valid), 32'd0);
    check({tag, " ovf"},     32'(overflow), 32'd0);
    check({tag, " total"},   32'(toggle_total), 32'd0);
    check({tag, " total_s"}, 32'(toggle_total_s), 32'd0);
    for (int b = 0; b < WIDTH; b++) begin
      bit_sel = 3'(b);
      #1;
      check($sformatf("%s bit%0d", tag, b), 32'(bit_count), 32'd0);
    end
    bit_sel = 3'd0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    res_ready = 1'b0;
    probe     = '0;
    bit_sel   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_cleared("reset");

    run_window("const5a", 0, 5, 1'b0);
    run_window("alt", 1, 3, 1'b1);
    run_window("bit0", 2, 2, 1'b0);

    // Reset in the middle of the 5th COUNT cycle discards the measurement
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      probe = (k % 2 == 1) ? 8'hFF : 8'h00;
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    start = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    res_ready = 1'b0;
    check_cleared("midrst");
    @(posedge clk);
    @(negedge clk);
    check("midrst stays idle", 32'(busy), 32'd0);
    run_window("alt_after_rst", 1, 1, 1'b0);

    for (int n = 0; n < 6; n++) begin
      run_window($sformatf("rand%0d", n), 3, int'($urandom_range(0, 4)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
